// File: rtl/svsm_pkg.sv
// Shared constants and element type for the signed vector-scalar multiplier.
// Elements are sign-magnitude fixed point: {sign, INT_W integer bits, FRAC_W fraction bits}.
package svsm_pkg;

  localparam int unsigned INT_W_D    = 8;
  localparam int unsigned FRAC_W_D   = 10;
  localparam int unsigned CHANNELS_D = 3;

  // Magnitude width and full element width for the default configuration
  localparam int unsigned MW = INT_W_D + FRAC_W_D;
  localparam int unsigned EW = 1 + MW;

  typedef struct packed {
    logic          sign;
    logic [MW-1:0] mag;
  } sm_elem_t;

endpackage

// File: rtl/sm_fixed_mul.sv
// One channel of the sign-magnitude multiplier: S1 holds the raw product and
// sign, S2 holds the shifted/saturated result.
// Optional feature: define SVSM_ROUND_EN to round half up on the magnitude
// before the fraction bits are dropped; otherwise they are truncated.
module sm_fixed_mul #(
  parameter int unsigned INT_W  = 8,
  parameter int unsigned FRAC_W = 10
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    en,
  input  logic [INT_W+FRAC_W:0]   a,
  input  logic [INT_W+FRAC_W:0]   b,
  output logic [INT_W+FRAC_W:0]   res,
  output logic                    ovf
);

  localparam int unsigned MW = INT_W + FRAC_W;
  localparam int unsigned PW = 2 * MW;
  localparam int unsigned SW = PW + 1;

`ifdef SVSM_ROUND_EN
  localparam logic [SW-1:0] RND = SW'(1) << (FRAC_W - 1);
`else
  localparam logic [SW-1:0] RND = '0;
`endif

  logic [PW-1:0] s1_prod;
  logic          s1_sign;

  logic [SW-1:0] sum_c;
  logic [SW-1:0] shf_c;
  logic [MW-1:0] mag_c;
  logic          ovf_c;
  logic          sign_c;

  // S1: full unsigned magnitude product and XOR of the signs
  always_ff @(posedge clk) begin
    if (rst) begin
      s1_prod <= '0;
      s1_sign <= 1'b0;
    end else if (en) begin
      s1_prod <= PW'(a[MW-1:0]) * PW'(b[MW-1:0]);
      s1_sign <= a[MW] ^ b[MW];
    end
  end

  // Round (optional), drop fraction bits, saturate, and suppress negative zero
  always_comb begin
    sum_c  = SW'(s1_prod) + RND;
    shf_c  = sum_c >> FRAC_W;
    ovf_c  = |shf_c[SW-1:MW];
    mag_c  = ovf_c ? '1 : shf_c[MW-1:0];
    sign_c = s1_sign && (mag_c != '0);
  end

  // S2: registered result element and saturation flag
  always_ff @(posedge clk) begin
    if (rst) begin
      res <= '0;
      ovf <= 1'b0;
    end else if (en) begin
      res <= {sign_c, mag_c};
      ovf <= ovf_c;
    end
  end

endmodule

// File: rtl/signed_vector_scalar_mul_pipe.sv
// Two-stage pipelined multiply of a sign-magnitude vector by a sign-magnitude
// scalar with per-channel saturation flags and a sticky overflow indicator.
// Optional feature: define SVSM_ROUND_EN to round half up instead of truncating.
module signed_vector_scalar_mul_pipe
  import svsm_pkg::*;
#(
  parameter int unsigned INT_W    = INT_W_D,
  parameter int unsigned FRAC_W   = FRAC_W_D,
  parameter int unsigned CHANNELS = CHANNELS_D
) (
  input  logic                                  clk,
  input  logic                                  rst,
  input  logic                                  in_valid,
  output logic                                  in_ready,
  input  logic [INT_W+FRAC_W:0]                 in_scalar,
  input  logic [CHANNELS*(1+INT_W+FRAC_W)-1:0]  in_vector,
  output logic                                  out_valid,
  input  logic                                  out_ready,
  output logic [CHANNELS*(1+INT_W+FRAC_W)-1:0]  out_vector,
  output logic [CHANNELS-1:0]                   out_ovf,
  output logic                                  ovf_sticky
);

  localparam int unsigned ELEM_W = 1 + INT_W + FRAC_W;

  logic en;
  logic s1_valid;

  // Whole pipeline advances whenever the output slot is empty or being drained
  assign en       = !out_valid || out_ready;
  assign in_ready = en;

  // Valid bits travel with the data; bubbles are kept, not collapsed
  always_ff @(posedge clk) begin
    if (rst) begin
      s1_valid  <= 1'b0;
      out_valid <= 1'b0;
    end else if (en) begin
      s1_valid  <= in_valid;
      out_valid <= s1_valid;
    end
  end

  // Sticky overflow set by any delivered result carrying a saturated channel
  always_ff @(posedge clk) begin
    if (rst) begin
      ovf_sticky <= 1'b0;
    end else if (out_valid && out_ready && (|out_ovf)) begin
      ovf_sticky <= 1'b1;
    end
  end

  // Channel 0 sits in the MSBs of both vectors and of out_ovf
  for (genvar ch = 0; ch < CHANNELS; ch++) begin : g_ch
    sm_fixed_mul #(
      .INT_W  (INT_W),
      .FRAC_W (FRAC_W)
    ) u_mul (
      .clk (clk),
      .rst (rst),
      .en  (en),
      .a   (in_scalar),
      .b   (in_vector[(CHANNELS-1-ch)*ELEM_W +: ELEM_W]),
      .res (out_vector[(CHANNELS-1-ch)*ELEM_W +: ELEM_W]),
      .ovf (out_ovf[CHANNELS-1-ch])
    );
  end

endmodule

// File: tb/tb_signed_vector_scalar_mul_pipe.sv
// Directed bench for signed_vector_scalar_mul_pipe (default 8.10 format, 3 channels).
// Expectations for the rounding cases follow SVSM_ROUND_EN.
module tb_signed_vector_scalar_mul_pipe;

  localparam int unsigned EW = 19;
  localparam int unsigned VW = 3 * EW;

`ifdef SVSM_ROUND_EN
  localparam logic [EW-1:0] EXP_HALF     = 19'h00001;
  localparam logic [EW-1:0] EXP_NEG_HALF = 19'h40001;
`else
  localparam logic [EW-1:0] EXP_HALF     = 19'h00000;
  localparam logic [EW-1:0] EXP_NEG_HALF = 19'h00000;
`endif

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          in_valid = 1'b0;
  logic          in_ready;
  logic [EW-1:0] in_scalar = '0;
  logic [VW-1:0] in_vector = '0;
  logic          out_valid;
  logic          out_ready = 1'b0;
  logic [VW-1:0] out_vector;
  logic [2:0]    out_ovf;
  logic          ovf_sticky;

  int compared   = 0;
  int mismatched = 0;

  signed_vector_scalar_mul_pipe dut (
    .clk        (clk),
    .rst        (rst),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .in_scalar  (in_scalar),
    .in_vector  (in_vector),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .out_vector (out_vector),
    .out_ovf    (out_ovf),
    .ovf_sticky (ovf_sticky)
  );

  always #5 clk = ~clk;

  // Push one beat into an empty pipe and capture the first result seen
  task automatic run_single(input logic [EW-1:0] sc, input logic [VW-1:0] vec,
                            output logic [VW-1:0] res, output logic [2:0] ovf,
                            output int lat);
    @(negedge clk);
    out_ready = 1'b1;
    in_scalar = sc;
    in_vector = vec;
    in_valid  = 1'b1;
    @(posedge clk);
    #1;
    in_valid  = 1'b0;
    in_scalar = '0;
    in_vector = '0;
    lat = 0;
    res = '0;
    ovf = '0;
    for (int i = 1; i <= 10; i++) begin
      @(negedge clk);
      if (out_valid) begin
        lat = i;
        res = out_vector;
        ovf = out_ovf;
        break;
      end
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    out_ready = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    compared++;
    if (out_valid !== 1'b0) begin
      mismatched++; $display("FAIL reset_out_valid: got %b expected 0", out_valid);
    end
    compared++;
    if (ovf_sticky !== 1'b0) begin
      mismatched++; $display("FAIL reset_sticky: got %b expected 0", ovf_sticky);
    end
    compared++;
    if (in_ready !== 1'b1) begin
      mismatched++; $display("FAIL reset_in_ready: got %b expected 1", in_ready);
    end
    compared++;
    if (out_vector !== '0) begin
      mismatched++; $display("FAIL reset_out_vector: got %h expected 0", out_vector);
    end
    compared++;
    if (out_ovf !== 3'b000) begin
      mismatched++; $display("FAIL reset_out_ovf: got %b expected 000", out_ovf);
    end
  endtask

  task automatic test_basic();
    logic [VW-1:0] res;
    logic [2:0]    ovf;
    int            lat;
    logic [VW-1:0] exp_v;
    exp_v = {19'h01900, 19'h01900, 19'h01900};
    run_single(19'h00A00, {19'h00A00, 19'h00A00, 19'h00A00}, res, ovf, lat);
    compared++;
    if (lat !== 2) begin
      mismatched++; $display("FAIL basic_latency: got %0d expected 2", lat);
    end
    compared++;
    if (res !== exp_v) begin
      mismatched++; $display("FAIL basic_vector: got %h expected %h", res, exp_v);
    end
    compared++;
    if (ovf !== 3'b000) begin
      mismatched++; $display("FAIL basic_ovf: got %b expected 000", ovf);
    end
  endtask

  task automatic test_rounding();
    logic [VW-1:0] res;
    logic [2:0]    ovf;
    int            lat;
    logic [VW-1:0] exp_v;
    exp_v = {EXP_HALF, EXP_HALF, EXP_HALF};
    run_single(19'h00001, {19'h00200, 19'h00200, 19'h00200}, res, ovf, lat);
    compared++;
    if (res !== exp_v) begin
      mismatched++; $display("FAIL round_half: got %h expected %h", res, exp_v);
    end
    exp_v = {EXP_NEG_HALF, EXP_NEG_HALF, EXP_NEG_HALF};
    run_single(19'h40001, {19'h00200, 19'h00200, 19'h00200}, res, ovf, lat);
    compared++;
    if (res !== exp_v) begin
      mismatched++; $display("FAIL round_neg_half: got %h expected %h", res, exp_v);
    end
  endtask

  task automatic test_neg_zero();
    logic [VW-1:0] res;
    logic [2:0]    ovf;
    int            lat;
    run_single(19'h40000, {19'h00C00, 19'h40C00, 19'h00000}, res, ovf, lat);
    compared++;
    if (res !== '0) begin
      mismatched++; $display("FAIL neg_zero_vector: got %h expected 0", res);
    end
    compared++;
    if (ovf !== 3'b000) begin
      mismatched++; $display("FAIL neg_zero_ovf: got %b expected 000", ovf);
    end
  endtask

  task automatic test_saturation();
    logic [VW-1:0] res;
    logic [2:0]    ovf;
    int            lat;
    logic [VW-1:0] exp_v;
    // Largest magnitude times 1.0 fits; times one LSB more than 1.0 saturates
    exp_v = {19'h3FFFF, 19'h3FFFF, 19'h7FFFF};
    run_single(19'h3FFFF, {19'h00400, 19'h00401, 19'h40400}, res, ovf, lat);
    compared++;
    if (res !== exp_v) begin
      mismatched++; $display("FAIL sat_edge_vector: got %h expected %h", res, exp_v);
    end
    compared++;
    if (ovf !== 3'b010) begin
      mismatched++; $display("FAIL sat_edge_ovf: got %b expected 010", ovf);
    end
    @(negedge clk);
    compared++;
    if (ovf_sticky !== 1'b1) begin
      mismatched++; $display("FAIL sat_edge_sticky: got %b expected 1", ovf_sticky);
    end
  endtask

  task automatic test_sticky();
    logic [VW-1:0] res;
    logic [2:0]    ovf;
    int            lat;
    logic [VW-1:0] exp_v;
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    compared++;
    if (ovf_sticky !== 1'b0) begin
      mismatched++; $display("FAIL sticky_cleared: got %b expected 0", ovf_sticky);
    end
    exp_v = {19'h7FFFF, 19'h72000, 19'h00000};
    run_single(19'h72000, {19'h00800, 19'h00400, 19'h00000}, res, ovf, lat);
    compared++;
    if (res !== exp_v) begin
      mismatched++; $display("FAIL sat_vector: got %h expected %h", res, exp_v);
    end
    compared++;
    if (ovf !== 3'b100) begin
      mismatched++; $display("FAIL sat_ovf: got %b expected 100", ovf);
    end
    compared++;
    if (ovf_sticky !== 1'b0) begin
      mismatched++; $display("FAIL sticky_before_transfer: got %b expected 0", ovf_sticky);
    end
    @(negedge clk);
    compared++;
    if (ovf_sticky !== 1'b1) begin
      mismatched++; $display("FAIL sticky_after_transfer: got %b expected 1", ovf_sticky);
    end
  endtask

  task automatic test_back_to_back();
    logic [VW-1:0] vin  [4];
    logic [VW-1:0] vexp [4];
    logic [VW-1:0] hold_v;
    logic [2:0]    hold_o;
    logic          stalled;
    bit            pat  [4];
    int            sent;
    int            rcv;
    pat  = '{1'b1, 1'b0, 1'b0, 1'b1};
    vin  = '{{19'h00100, 19'h00200, 19'h40300},
             {19'h00001, 19'h40001, 19'h00000},
             {19'h01000, 19'h02000, 19'h03000},
             {19'h0FFFF, 19'h00000, 19'h00010}};
    vexp = '{{19'h00200, 19'h00400, 19'h40600},
             {19'h00002, 19'h40002, 19'h00000},
             {19'h02000, 19'h04000, 19'h06000},
             {19'h1FFFE, 19'h00000, 19'h00020}};
    sent = 0;
    rcv = 0;
    stalled = 1'b0;
    hold_v = '0;
    hold_o = '0;
    for (int c = 0; c < 40 && rcv < 4; c++) begin
      @(negedge clk);
      if (stalled) begin
        compared++;
        if (out_valid !== 1'b1 || out_vector !== hold_v || out_ovf !== hold_o) begin
          mismatched++;
          $display("FAIL b2b_stall_stable: got v=%b %h/%b expected v=1 %h/%b",
                   out_valid, out_vector, out_ovf, hold_v, hold_o);
        end
      end
      out_ready = pat[c % 4];
      if (sent < 4) begin
        in_valid  = 1'b1;
        in_scalar = 19'h00800;
        in_vector = vin[sent];
      end else begin
        in_valid  = 1'b0;
        in_vector = '0;
      end
      #1;
      if (out_valid && out_ready) begin
        compared++;
        if (out_vector !== vexp[rcv] || out_ovf !== 3'b000) begin
          mismatched++;
          $display("FAIL b2b_beat%0d: got %h/%b expected %h/000",
                   rcv, out_vector, out_ovf, vexp[rcv]);
        end
        rcv++;
      end
      stalled = out_valid && !out_ready;
      hold_v  = out_vector;
      hold_o  = out_ovf;
      if (in_valid && in_ready) sent++;
    end
    in_valid = 1'b0;
    out_ready = 1'b1;
    compared++;
    if (rcv !== 4) begin
      mismatched++; $display("FAIL b2b_count: got %0d expected 4", rcv);
    end
    repeat (4) begin
      @(negedge clk);
      compared++;
      if (out_valid !== 1'b0) begin
        mismatched++; $display("FAIL b2b_no_duplicate: got out_valid %b expected 0", out_valid);
      end
    end
  endtask

  task automatic test_reset_inflight();
    int stale;
    @(negedge clk);
    out_ready = 1'b1;
    in_valid  = 1'b1;
    in_scalar = 19'h32000;
    in_vector = {19'h00800, 19'h00800, 19'h00800};
    @(negedge clk);
    in_vector = {19'h00C00, 19'h00C00, 19'h00C00};
    @(negedge clk);
    in_valid = 1'b0;
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    compared++;
    if (out_valid !== 1'b0) begin
      mismatched++; $display("FAIL rst_inflight_valid: got %b expected 0", out_valid);
    end
    compared++;
    if (ovf_sticky !== 1'b0) begin
      mismatched++; $display("FAIL rst_inflight_sticky: got %b expected 0", ovf_sticky);
    end
    compared++;
    if (out_ovf !== 3'b000 || out_vector !== '0) begin
      mismatched++;
      $display("FAIL rst_inflight_data: got %h/%b expected 0/000", out_vector, out_ovf);
    end
    stale = 0;
    repeat (8) begin
      @(negedge clk);
      if (out_valid) stale++;
    end
    compared++;
    if (stale !== 0) begin
      mismatched++; $display("FAIL rst_inflight_stale: got %0d beats expected 0", stale);
    end
    compared++;
    if (ovf_sticky !== 1'b0) begin
      mismatched++; $display("FAIL rst_inflight_sticky_late: got %b expected 0", ovf_sticky);
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_rounding();
    test_neg_zero();
    test_saturation();
    test_sticky();
    test_back_to_back();
    test_reset_inflight();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
